// File: rtl/div_pkg.sv
// Shared sizing for the sequential restoring divider: default operand width
// and the step-counter width helper.
package div_pkg;

  localparam int DIV_LEN = 16;

  // Counter must hold the value LEN itself, hence LEN+1 states.
  function automatic int cnt_w(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract
// the divisor, keep the difference and set the quotient bit when no borrow.
module div_step
    import div_pkg::*;
#(
    parameter int LEN = DIV_LEN
) (
    input  logic [LEN-1:0] rem,
    input  logic [LEN-1:0] quo,
    input  logic [LEN-1:0] dvs,
    output logic [LEN-1:0] rem_nx,
    output logic [LEN-1:0] quo_nx
);

    logic [2*LEN-1:0] sh;
    logic [LEN:0]     t;

    always_comb begin
        sh = {rem, quo} << 1;
        // t[LEN] is the borrow of the trial subtraction.
        t  = {1'b0, sh[2*LEN-1:LEN]} - {1'b0, dvs};
        if (!t[LEN]) begin
            rem_nx = t[LEN-1:0];
            quo_nx = {sh[LEN-1:1], 1'b1};
        end else begin
            rem_nx = sh[2*LEN-1:LEN];
            quo_nx = sh[LEN-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Sequential unsigned divider producing one quotient bit per clock, with a
// START/DONE handshake and a divide-by-zero shortcut that finishes in one step.
module div_seq
    import div_pkg::*;
#(
    parameter int LEN = DIV_LEN
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           START,
    input  logic [LEN-1:0] A,
    input  logic [LEN-1:0] B,
    output logic           DONE,
    output logic [LEN-1:0] Q,
    output logic [LEN-1:0] R,
    output logic           DBZ
);

    localparam int CNT_W = cnt_w(LEN);

    logic [LEN-1:0]   quo;
    logic [LEN-1:0]   rem;
    logic [LEN-1:0]   dvs;
    logic [CNT_W-1:0] cnt;
    logic             dbz;
    logic [LEN-1:0]   rem_nx;
    logic [LEN-1:0]   quo_nx;

    div_step #(.LEN(LEN)) u_step (
        .rem    (rem),
        .quo    (quo),
        .dvs    (dvs),
        .rem_nx (rem_nx),
        .quo_nx (quo_nx)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            dvs <= '0;
            dbz <= 1'b0;
        end else if (START) begin
            quo <= A;
            rem <= '0;
            dvs <= B;
            if (B != '0) begin
                cnt <= CNT_W'(LEN);
                dbz <= 1'b0;
            end else begin
                cnt <= CNT_W'(1);
                dbz <= 1'b1;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            // Divide-by-zero: quo still holds A, so finish with the
            // restoring-algorithm result for B=0 in a single step.
            if (dbz) begin
                quo <= '1;
                rem <= quo;
            end else begin
                quo <= quo_nx;
                rem <= rem_nx;
            end
        end
    end

    assign DONE = (cnt == '0);
    assign Q    = quo;
    assign R    = rem;
    assign DBZ  = dbz;

endmodule
